// File: rtl/vga_sync_gen.sv
// VGA raster timing generator (640x480@60 by default) running on the pixel clock.
// Every output is a register loaded from the next counter values, so sync/blank flags line up with Pixel_x/Pixel_y.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       Pixel_clock,
  input  logic       Reset,
  output logic       Hsync,
  output logic       Vsync,
  output logic       Video_on,
  output logic [9:0] Pixel_x,
  output logic [9:0] Pixel_y,
  output logic       Frame_tick,
  output logic [7:0] Frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_tick_q, frame_tick_d;
  logic [7:0] frame_count_q, frame_count_d;

  always_comb begin
    pixel_x_d     = pixel_x_q + 10'd1;
    pixel_y_d     = pixel_y_q;
    frame_count_d = frame_count_q;

    if (pixel_x_q == H_LAST) begin
      pixel_x_d = '0;
      if (pixel_y_q == V_LAST) begin
        pixel_y_d = '0;
      end else begin
        pixel_y_d = pixel_y_q + 10'd1;
      end
    end

    // Flags are decoded from the position the counters are about to enter.
    hsync_d = ((pixel_x_d >= H_SYNC_BEG) && (pixel_x_d <= H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((pixel_y_d >= V_SYNC_BEG) && (pixel_y_d <= V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_d   = (pixel_x_d < H_VIS) && (pixel_y_d < V_VIS);
    frame_tick_d = (pixel_x_d == '0) && (pixel_y_d == V_VIS);

    if (frame_tick_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge Pixel_clock or posedge Reset) begin
    if (Reset) begin
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign Pixel_x     = pixel_x_q;
  assign Pixel_y     = pixel_y_q;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign Video_on    = video_on_q;
  assign Frame_tick  = frame_tick_q;
  assign Frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for horizontal timing and reset,
// and a shrunken instance (16x8 raster, active-high sync) for frame-level behaviour.
module tb_vga_sync_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  // Full-size 640x480 instance
  logic       d_hs, d_vs, d_von, d_tick;
  logic [9:0] d_x, d_y;
  logic [7:0] d_cnt;

  vga_sync_gen dut_d (
    .Pixel_clock (clk),
    .Reset       (rst_d),
    .Hsync       (d_hs),
    .Vsync       (d_vs),
    .Video_on    (d_von),
    .Pixel_x     (d_x),
    .Pixel_y     (d_y),
    .Frame_tick  (d_tick),
    .Frame_count (d_cnt)
  );

  // Small instance: H 8+2+3+3=16, V 4+1+2+1=8, sync active high.
  // Hsync high for x 10..12, Vsync high for y 5..6, visible x<8 && y<4, tick at (0,4).
  logic       s_hs, s_vs, s_von, s_tick;
  logic [9:0] s_x, s_y;
  logic [7:0] s_cnt;

  vga_sync_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
    .SYNC_POL  (1'b1)
  ) dut_s (
    .Pixel_clock (clk),
    .Reset       (rst_s),
    .Hsync       (s_hs),
    .Vsync       (s_vs),
    .Video_on    (s_von),
    .Pixel_x     (s_x),
    .Pixel_y     (s_y),
    .Frame_tick  (s_tick),
    .Frame_count (s_cnt)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  int cur_n = 0;

  task automatic step_to(input int target);
    while (cur_n < target) begin
      @(negedge clk);
      cur_n++;
    end
  endtask

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int lows, falls, first_fall, second_fall;
    logic prev_hs;
    int von_f, vs_f, hs_f, err_f, exp_cnt, frame_idx;
    int ex, ey;
    logic ehs, evs, evon, etick;
    logic [7:0] prev_cnt, popped;

    // n = rising edges since reset release; position = (n % 800, n / 800)
    tbl[0]  = '{1,    10'd1,   10'd0,  1'b1, 1'b1, 1'b1};
    tbl[1]  = '{639,  10'd639, 10'd0,  1'b1, 1'b1, 1'b1};
    tbl[2]  = '{640,  10'd640, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{655,  10'd655, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[4]  = '{656,  10'd656, 10'd0,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{751,  10'd751, 10'd0,  1'b0, 1'b1, 1'b0};
    tbl[6]  = '{752,  10'd752, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{799,  10'd799, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{800,  10'd0,   10'd1,  1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1456, 10'd656, 10'd1,  1'b0, 1'b1, 1'b0};
    tbl[10] = '{8799, 10'd799, 10'd10, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{8800, 10'd0,   10'd11, 1'b1, 1'b1, 1'b1};

    // ---- reset values, both instances ----
    repeat (3) @(negedge clk);
    chk("rst_d_x", d_x, 0);
    chk("rst_d_y", d_y, 0);
    chk("rst_d_hs", d_hs, 1);
    chk("rst_d_vs", d_vs, 1);
    chk("rst_d_von", d_von, 0);
    chk("rst_d_tick", d_tick, 0);
    chk("rst_d_cnt", d_cnt, 0);
    chk("rst_s_hs", s_hs, 0);
    chk("rst_s_vs", s_vs, 0);

    // ---- full-size instance: table-driven horizontal timing ----
    rst_d = 1'b0;
    cur_n = 0;
    foreach (tbl[i]) begin
      step_to(tbl[i].n);
      chk($sformatf("tbl%0d_x", i), d_x, tbl[i].x);
      chk($sformatf("tbl%0d_y", i), d_y, tbl[i].y);
      chk($sformatf("tbl%0d_hs", i), d_hs, tbl[i].hs);
      chk($sformatf("tbl%0d_vs", i), d_vs, tbl[i].vs);
      chk($sformatf("tbl%0d_von", i), d_von, tbl[i].von);
      chk($sformatf("tbl%0d_tick", i), d_tick, 0);
      chk($sformatf("tbl%0d_cnt", i), d_cnt, 0);
    end

    // ---- Hsync width and period over two lines ----
    lows = 0; falls = 0; first_fall = 0; second_fall = 0;
    prev_hs = d_hs;
    for (int k = 0; k < 1600; k++) begin
      @(negedge clk);
      cur_n++;
      if (d_hs == 1'b0) lows++;
      if (prev_hs && !d_hs) begin
        falls++;
        if (falls == 1) begin
          first_fall = cur_n;
          chk("hs_fall_x", d_x, 656);
        end else begin
          second_fall = cur_n;
        end
      end
      prev_hs = d_hs;
    end
    chk("hs_low_cycles", lows, 192);
    chk("hs_falls", falls, 2);
    chk("hs_period", second_fall - first_fall, 800);

    // ---- asynchronous reset mid-line at (300,13) ----
    step_to(13 * 800 + 300);
    chk("pre_rst_x", d_x, 300);
    chk("pre_rst_y", d_y, 13);
    @(posedge clk);
    #2 rst_d = 1'b1;
    #1;
    chk("async_rst_x", d_x, 0);
    chk("async_rst_y", d_y, 0);
    chk("async_rst_hs", d_hs, 1);
    chk("async_rst_vs", d_vs, 1);
    chk("async_rst_von", d_von, 0);
    chk("async_rst_cnt", d_cnt, 0);
    @(negedge clk);
    rst_d = 1'b0;
    @(negedge clk);
    chk("post_rst_x", d_x, 1);
    chk("post_rst_y", d_y, 0);

    // ---- small instance: 257 ticks, frame statistics, count wrap ----
    for (int k = 1; k <= 257; k++) exp_q.push_back(8'(k % 256));
    @(negedge clk);
    rst_s = 1'b0;
    von_f = 0; vs_f = 0; hs_f = 0; err_f = 0; exp_cnt = 0; frame_idx = 0;
    prev_cnt = 8'd0;
    for (int n = 1; n <= 64 + 256 * 128; n++) begin
      @(negedge clk);
      if (n % 128 == 0) begin
        chk($sformatf("frame%0d_von", frame_idx), von_f, (frame_idx == 0) ? 31 : 32);
        chk($sformatf("frame%0d_vs", frame_idx), vs_f, 32);
        chk($sformatf("frame%0d_hs", frame_idx), hs_f, 24);
        chk($sformatf("frame%0d_cycle_errs", frame_idx), err_f, 0);
        von_f = 0; vs_f = 0; hs_f = 0; err_f = 0;
        frame_idx++;
      end
      ex = n % 16;
      ey = (n / 16) % 8;
      ehs   = (ex >= 10) && (ex <= 12);
      evs   = (ey >= 5) && (ey <= 6);
      evon  = (ex < 8) && (ey < 4);
      etick = (ex == 0) && (ey == 4);
      if (etick) exp_cnt++;
      if (s_x !== 10'(ex) || s_y !== 10'(ey) || s_hs !== ehs || s_vs !== evs ||
          s_von !== evon || s_tick !== etick || s_cnt !== 8'(exp_cnt % 256))
        err_f++;
      if (s_von === 1'b1) von_f++;
      if (s_vs === 1'b1) vs_f++;
      if (s_hs === 1'b1) hs_f++;
      if (s_tick === 1'b1) begin
        if (exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          chk("tick_count", s_cnt, popped);
        end else begin
          chk("tick_extra", 1, 0);
        end
        if (exp_cnt == 256) begin
          chk("wrap_prev", prev_cnt, 255);
          chk("wrap_now", s_cnt, 0);
        end
      end
      prev_cnt = s_cnt;
    end
    chk("ticks_remaining", exp_q.size(), 0);
    chk("final_cnt", s_cnt, 1);
    chk("tail_cycle_errs", err_f, 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
